xb_fwd_pipe: RTL and testbench

Parametrised writeback crossbar with a multi-stage forwarding history. It sits between the compute units, the broadcast path and the register file. It selects one write source per cycle and carries the selected writes through a FWD_DEPTH-deep writeback pipeline before committing them to the register file. While a write is in flight, any read of its address on the x/y ports returns the youngest in-flight value.

---
 rtl/xb_pkg.sv | 23 ++
 rtl/xb_fwd_pipe_if.sv | 50 +++++
 rtl/xb_wsel.sv | 40 ++++
 rtl/xb_fwd_pipe.sv | 135 +++++++++++++
 tb/tb_xb_fwd_pipe.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xb_pkg.sv
//------------------------------------------------------------------------------
// xb_pkg
// Shared definitions for the writeback crossbar / forwarding pipe:
//   - default width constants used as parameter defaults
//   - xb_hist_t, one forwarding-history entry {valid, addr, data} at the
//     default widths
// Optional feature macro used by this slice: XB_ONEHOT_CHK_EN.
//------------------------------------------------------------------------------
package xb_pkg;

   localparam int XB_DATA_WIDTH    = 16;
   localparam int XB_ADDRESS_WIDTH = 4;
   localparam int XB_N_UNITS       = 3;
   localparam int XB_FWD_DEPTH     = 2;

   // One in-flight write at the default widths.
   typedef struct packed {
      logic                        valid;
      logic [XB_ADDRESS_WIDTH-1:0] addr;
      logic [XB_DATA_WIDTH-1:0]    data;
   } xb_hist_t;

endpackage

// File: rtl/xb_fwd_pipe_if.sv
//------------------------------------------------------------------------------
// xb_fwd_pipe_if
// Bundles the crossbar's control, data and register-file signals.
//   master : the pipeline/compute side (drives enables, addresses, data,
//            register-file read data; observes operands and write port)
//   slave  : xb_fwd_pipe itself
// Signals:
//   ps_xb_stall, ps_xb_w_cuEn[N_UNITS], ps_xb_w_bcEn, ps_xb_wadd,
//   ps_xb_raddx, ps_xb_raddy, cu_xb_dt[N_UNITS*DATA_WIDTH], bc_dt,
//   rf_xb_dtx, rf_xb_dty                          (master -> slave)
//   xb_dtx, xb_dty, xb_rf_w_En, xb_rf_wadd, xb_rf_dt (slave -> master)
//------------------------------------------------------------------------------
interface xb_fwd_pipe_if
   import xb_pkg::*;
#(
   parameter int DATA_WIDTH    = XB_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = XB_ADDRESS_WIDTH,
   parameter int N_UNITS       = XB_N_UNITS
);

   logic                          ps_xb_stall;
   logic [N_UNITS-1:0]            ps_xb_w_cuEn;
   logic                          ps_xb_w_bcEn;
   logic [ADDRESS_WIDTH-1:0]      ps_xb_wadd;
   logic [ADDRESS_WIDTH-1:0]      ps_xb_raddx;
   logic [ADDRESS_WIDTH-1:0]      ps_xb_raddy;
   logic [N_UNITS*DATA_WIDTH-1:0] cu_xb_dt;
   logic [DATA_WIDTH-1:0]         bc_dt;
   logic [DATA_WIDTH-1:0]         rf_xb_dtx;
   logic [DATA_WIDTH-1:0]         rf_xb_dty;

   logic [DATA_WIDTH-1:0]         xb_dtx;
   logic [DATA_WIDTH-1:0]         xb_dty;
   logic                          xb_rf_w_En;
   logic [ADDRESS_WIDTH-1:0]      xb_rf_wadd;
   logic [DATA_WIDTH-1:0]         xb_rf_dt;

   modport master (
      output ps_xb_stall, ps_xb_w_cuEn, ps_xb_w_bcEn, ps_xb_wadd,
             ps_xb_raddx, ps_xb_raddy, cu_xb_dt, bc_dt, rf_xb_dtx, rf_xb_dty,
      input  xb_dtx, xb_dty, xb_rf_w_En, xb_rf_wadd, xb_rf_dt
   );

   modport slave (
      input  ps_xb_stall, ps_xb_w_cuEn, ps_xb_w_bcEn, ps_xb_wadd,
             ps_xb_raddx, ps_xb_raddy, cu_xb_dt, bc_dt, rf_xb_dtx, rf_xb_dty,
      output xb_dtx, xb_dty, xb_rf_w_En, xb_rf_wadd, xb_rf_dt
   );

endinterface

// File: rtl/xb_wsel.sv
//------------------------------------------------------------------------------
// xb_wsel
// Priority write-source selector. The lowest-indexed enabled compute unit
// wins; the broadcast source is taken only when no unit is enabled.
// Ports:
//   cu_en  [N_UNITS]            per-unit write enables
//   bc_en                       broadcast write enable
//   cu_dt  [N_UNITS*DATA_WIDTH] unit results, unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bc_dt  [DATA_WIDTH]         broadcast data
//   req                         any source requesting
//   sel_dt [DATA_WIDTH]         winning data (0 when nothing requests)
//------------------------------------------------------------------------------
module xb_wsel
   import xb_pkg::*;
#(
   parameter int N_UNITS    = XB_N_UNITS,
   parameter int DATA_WIDTH = XB_DATA_WIDTH
) (
   input  logic [N_UNITS-1:0]            cu_en,
   input  logic                          bc_en,
   input  logic [N_UNITS*DATA_WIDTH-1:0] cu_dt,
   input  logic [DATA_WIDTH-1:0]         bc_dt,
   output logic                          req,
   output logic [DATA_WIDTH-1:0]         sel_dt
);

   always_comb begin
      // NOTE: every output gets a default before any conditional assignment,
      // so no path leaves it unassigned and no latch is inferred.
      req    = (|cu_en) | bc_en;
      sel_dt = bc_en ? bc_dt : '0;
      // Scan from the top down so the lowest set index is written last.
      for (int i = N_UNITS - 1; i >= 0; i--) begin
         if (cu_en[i]) begin
            sel_dt = cu_dt[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/xb_fwd_pipe.sv
//------------------------------------------------------------------------------
// xb_fwd_pipe
// Writeback crossbar with a FWD_DEPTH-deep forwarding history. One write
// source is selected per cycle (xb_wsel), carried through the history
// (stage 0 youngest) and committed to the register file from the last stage.
// Reads on x/y return the youngest in-flight value for their address.
// Ports:
//   clk_dcd        clock, all state on rising edge
//   rst_n          synchronous active-low reset (wins over stall)
//   bus (slave)    control/data/register-file signals, see xb_fwd_pipe_if
//   xb_err_onehot  sticky multi-source flag, present only when the macro
//                  XB_ONEHOT_CHK_EN is defined
//------------------------------------------------------------------------------
module xb_fwd_pipe
   import xb_pkg::*;
#(
   parameter int DATA_WIDTH    = XB_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = XB_ADDRESS_WIDTH,
   parameter int N_UNITS       = XB_N_UNITS,
   parameter int FWD_DEPTH     = XB_FWD_DEPTH
) (
   input  logic clk_dcd,
   input  logic rst_n,
`ifdef XB_ONEHOT_CHK_EN
   output logic xb_err_onehot,
`endif
   xb_fwd_pipe_if.slave bus
);

   // History entry at this instance's widths (xb_hist_t is the default-width
   // form of the same record).
   typedef struct packed {
      logic                     valid;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } entry_t;

   entry_t                hist_q [FWD_DEPTH];
   logic                  cur_req;
   logic [DATA_WIDTH-1:0] cur_dt;
   logic                  cur_fwd;

   xb_wsel #(
      .N_UNITS    (N_UNITS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wsel (
      .cu_en  (bus.ps_xb_w_cuEn),
      .bc_en  (bus.ps_xb_w_bcEn),
      .cu_dt  (bus.cu_xb_dt),
      .bc_dt  (bus.bc_dt),
      .req    (cur_req),
      .sel_dt (cur_dt)
   );

   // A request is only real when the pipe advances; a stalled request is
   // dropped, so it must not be forwarded either.
   assign cur_fwd = cur_req & ~bus.ps_xb_stall;

   //---------------------------------------------------------------------------
   // History shift register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk_dcd) begin
      // NOTE: the history is a handful of flops, not a RAM, and in-flight
      // writes must vanish on reset, so every stage is cleared here.
      if (!rst_n) begin
         for (int k = 0; k < FWD_DEPTH; k++) begin
            // NOTE: non-blocking assignments let each stage take its
            // neighbour's pre-edge value regardless of statement order.
            hist_q[k] <= '0;
         end
      end else if (!bus.ps_xb_stall) begin
         hist_q[0] <= '{valid: cur_req, addr: bus.ps_xb_wadd, data: cur_dt};
         for (int k = 1; k < FWD_DEPTH; k++) begin
            hist_q[k] <= hist_q[k-1];
         end
      end
   end

   //---------------------------------------------------------------------------
   // Forwarding: current request, then stage 0 (youngest) .. last stage,
   // then the register file.
   //---------------------------------------------------------------------------
   function automatic logic [DATA_WIDTH-1:0] fwd_lookup(
      input logic [ADDRESS_WIDTH-1:0] raddr,
      input logic [DATA_WIDTH-1:0]    rf_dt
   );
      logic [DATA_WIDTH-1:0] res;
      res = rf_dt;
      // Oldest first, so younger matches overwrite older ones.
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (hist_q[k].valid && (hist_q[k].addr == raddr)) begin
            res = hist_q[k].data;
         end
      end
      if (cur_fwd && (bus.ps_xb_wadd == raddr)) begin
         res = cur_dt;
      end
      return res;
   endfunction

   always_comb begin
      bus.xb_dtx = fwd_lookup(bus.ps_xb_raddx, bus.rf_xb_dtx);
   end

   always_comb begin
      bus.xb_dty = fwd_lookup(bus.ps_xb_raddy, bus.rf_xb_dty);
   end

   //---------------------------------------------------------------------------
   // Commit port: the last stage leaves the pipe on the next unstalled edge,
   // which is exactly when the register file must take it.
   //---------------------------------------------------------------------------
   assign bus.xb_rf_w_En = hist_q[FWD_DEPTH-1].valid & ~bus.ps_xb_stall;
   assign bus.xb_rf_wadd = hist_q[FWD_DEPTH-1].addr;
   assign bus.xb_rf_dt   = hist_q[FWD_DEPTH-1].data;

`ifdef XB_ONEHOT_CHK_EN
   //---------------------------------------------------------------------------
   // Sticky flag: more than one source asserted on an unstalled edge.
   //---------------------------------------------------------------------------
   logic err_q;

   always_ff @(posedge clk_dcd) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (!bus.ps_xb_stall &&
                   ($countones({bus.ps_xb_w_cuEn, bus.ps_xb_w_bcEn}) > 1)) begin
         err_q <= 1'b1;
      end
   end

   assign xb_err_onehot = err_q;
`endif

endmodule

// File: tb/tb_xb_fwd_pipe.sv
//------------------------------------------------------------------------------
// tb_xb_fwd_pipe
// Self-checking bench for xb_fwd_pipe (16/4/3/2). Directed scenarios followed
// by randomized traffic, all compared against a reference model that keeps a
// log of the writes accepted on unstalled edges since the last reset.
// Define XB_ONEHOT_CHK_EN to also exercise xb_err_onehot.
//------------------------------------------------------------------------------
module tb_xb_fwd_pipe;
   import xb_pkg::*;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NU = 3;
   localparam int FD = 2;

   logic clk_dcd = 1'b0;
   logic rst_n;

   always #5 clk_dcd = ~clk_dcd;

   xb_fwd_pipe_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .N_UNITS(NU)) bus ();

`ifdef XB_ONEHOT_CHK_EN
   logic xb_err_onehot;
   bit   err_model;
`endif

   xb_fwd_pipe #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .N_UNITS       (NU),
      .FWD_DEPTH     (FD)
   ) dut (
      .clk_dcd       (clk_dcd),
      .rst_n         (rst_n),
`ifdef XB_ONEHOT_CHK_EN
      .xb_err_onehot (xb_err_onehot),
`endif
      .bus           (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Writes accepted on unstalled edges since reset; newest at the back.
   // Only the last FD are still in flight; the front one is about to commit.
   xb_hist_t wlog[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // The write the current inputs request (valid=0 when nothing requests).
   function automatic xb_hist_t model_sel();
      xb_hist_t e;
      e.valid = 1'b0;
      e.addr  = bus.ps_xb_wadd;
      e.data  = '0;
      for (int i = 0; i < NU; i++) begin
         if (bus.ps_xb_w_cuEn[i]) begin
            e.valid = 1'b1;
            e.data  = bus.cu_xb_dt[i*DW +: DW];
            return e;
         end
      end
      if (bus.ps_xb_w_bcEn) begin
         e.valid = 1'b1;
         e.data  = bus.bc_dt;
      end
      return e;
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] raddr,
                                                input logic [DW-1:0] rf_dt);
      xb_hist_t cur;
      xb_hist_t e;
      cur = model_sel();
      if (!bus.ps_xb_stall && cur.valid && cur.addr == raddr) return cur.data;
      for (int k = wlog.size() - 1; k >= 0; k--) begin
         e = wlog[k];
         if (e.valid && e.addr == raddr) return e.data;
      end
      return rf_dt;
   endfunction

   // Check all outputs in the middle of the cycle, then advance the model
   // across the rising edge; inputs change 1 time unit after that edge.
   task automatic cycle(input string tag);
      xb_hist_t cur;
      xb_hist_t last;
      bit       stall_s;
      bit       rst_s;
      bit       multi;
      @(negedge clk_dcd);
      check({tag, ".dtx"}, bus.xb_dtx, model_read(bus.ps_xb_raddx, bus.rf_xb_dtx));
      check({tag, ".dty"}, bus.xb_dty, model_read(bus.ps_xb_raddy, bus.rf_xb_dty));
      if (wlog.size() == FD) begin
         last = wlog[0];
         check({tag, ".wen"}, bus.xb_rf_w_En, last.valid & ~bus.ps_xb_stall);
         if (last.valid) begin
            check({tag, ".wadd"}, bus.xb_rf_wadd, last.addr);
            check({tag, ".wdt"},  bus.xb_rf_dt,   last.data);
         end
      end else begin
         // The last stage still holds its reset contents.
         check({tag, ".wen"},  bus.xb_rf_w_En, 1'b0);
         check({tag, ".wadd"}, bus.xb_rf_wadd, '0);
         check({tag, ".wdt"},  bus.xb_rf_dt,   '0);
      end
`ifdef XB_ONEHOT_CHK_EN
      check({tag, ".err"}, xb_err_onehot, err_model);
`endif
      cur     = model_sel();
      stall_s = bus.ps_xb_stall;
      rst_s   = ~rst_n;
      multi   = ($countones({bus.ps_xb_w_cuEn, bus.ps_xb_w_bcEn}) > 1);
      @(posedge clk_dcd);
      if (rst_s) begin
         wlog.delete();
`ifdef XB_ONEHOT_CHK_EN
         err_model = 1'b0;
`endif
      end else if (!stall_s) begin
         wlog.push_back(cur);
         if (wlog.size() > FD) void'(wlog.pop_front());
`ifdef XB_ONEHOT_CHK_EN
         if (multi) err_model = 1'b1;
`endif
      end
      if (multi && rst_s) ; // no effect beyond reset
      #1;
   endtask

   task automatic idle();
      rst_n            = 1'b1;
      bus.ps_xb_stall  = 1'b0;
      bus.ps_xb_w_cuEn = '0;
      bus.ps_xb_w_bcEn = 1'b0;
      bus.ps_xb_wadd   = '0;
      bus.cu_xb_dt     = '0;
      bus.bc_dt        = '0;
   endtask

   initial begin
      idle();
      rst_n           = 1'b0;
      bus.ps_xb_raddx = '0;
      bus.ps_xb_raddy = '0;
      bus.rf_xb_dtx   = 16'h1111;
      bus.rf_xb_dty   = 16'h3333;
`ifdef XB_ONEHOT_CHK_EN
      err_model = 1'b0;
`endif
      // First reset edge unchecked: state is unknown before it.
      @(posedge clk_dcd);
      #1;
      cycle("rst");
      rst_n = 1'b1;
      cycle("post_rst");

      // Basic commit and forwarding window on x.
      bus.ps_xb_raddx  = 4'd5;
      bus.ps_xb_w_cuEn = 3'b001;
      bus.ps_xb_wadd   = 4'd5;
      bus.cu_xb_dt     = {16'h0000, 16'h0000, 16'hA5A5};
      cycle("basic_t0");
      idle();
      for (int i = 0; i < 4; i++) cycle("basic_win");

      // Youngest wins on y.
      bus.ps_xb_raddy  = 4'd3;
      bus.ps_xb_w_cuEn = 3'b001;
      bus.ps_xb_wadd   = 4'd3;
      bus.cu_xb_dt     = {16'h0000, 16'h0000, 16'h0001};
      cycle("young_t0");
      bus.ps_xb_w_cuEn = 3'b010;
      bus.cu_xb_dt     = {16'h0000, 16'h0002, 16'h0000};
      cycle("young_t1");
      idle();
      for (int i = 0; i < 3; i++) cycle("young_tail");

      // Stall holds the pipe; a request during the stall is dropped.
      bus.ps_xb_raddx  = 4'd7;
      bus.ps_xb_w_cuEn = 3'b100;
      bus.ps_xb_wadd   = 4'd6;
      bus.cu_xb_dt     = {16'hBEEF, 16'h0000, 16'h0000};
      cycle("stall_t0");
      idle();
      bus.ps_xb_stall = 1'b1;
      cycle("stall_t1");
      bus.ps_xb_w_cuEn = 3'b100;
      bus.ps_xb_wadd   = 4'd7;
      bus.cu_xb_dt     = {16'hDEAD, 16'h0000, 16'h0000};
      cycle("stall_t2");
      idle();
      bus.ps_xb_stall = 1'b1;
      cycle("stall_t3");
      idle();
      for (int i = 0; i < 4; i++) cycle("stall_tail");

      // Priority among several sources; sticky flag when enabled.
      bus.ps_xb_raddx  = 4'd9;
      bus.ps_xb_w_cuEn = 3'b110;
      bus.ps_xb_w_bcEn = 1'b1;
      bus.ps_xb_wadd   = 4'd9;
      bus.cu_xb_dt     = {16'h3333, 16'h2222, 16'h0000};
      bus.bc_dt        = 16'h4444;
      cycle("prio_t0");
      idle();
      for (int i = 0; i < 4; i++) cycle("prio_tail");

      // Reset mid-flight discards the in-flight write.
      bus.ps_xb_raddx  = 4'd2;
      bus.ps_xb_w_cuEn = 3'b001;
      bus.ps_xb_wadd   = 4'd2;
      bus.cu_xb_dt     = {16'h0000, 16'h0000, 16'h5A5A};
      cycle("rmid_t0");
      idle();
      rst_n = 1'b0;
      cycle("rmid_t1");
      idle();
      for (int i = 0; i < 3; i++) cycle("rmid_tail");

      // Randomized traffic on a small address range to force collisions.
      for (int n = 0; n < 1500; n++) begin
         rst_n            = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         bus.ps_xb_stall  = ($urandom_range(0, 99) < 20);
         bus.ps_xb_w_cuEn = ($urandom_range(0, 2) == 0) ? '0 : NU'($urandom_range(0, 7));
         bus.ps_xb_w_bcEn = ($urandom_range(0, 1) == 1);
         bus.ps_xb_wadd   = AW'($urandom_range(0, 3));
         bus.ps_xb_raddx  = AW'($urandom_range(0, 3));
         bus.ps_xb_raddy  = AW'($urandom_range(0, 3));
         for (int i = 0; i < NU; i++) bus.cu_xb_dt[i*DW +: DW] = DW'($urandom);
         bus.bc_dt        = DW'($urandom);
         bus.rf_xb_dtx    = DW'($urandom);
         bus.rf_xb_dty    = DW'($urandom);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
